letc_core_limp_arbiter: RTL and testbench
=========================================

Name: letc_core_limp_arbiter

Overview:
- Two-requester arbiter sharing the single LIMP port of the core AXI FSM.
- Requester 0 is the instruction cache's backing-memory LIMP; requester 1 is the data cache's backing-memory LIMP.
- Grants one whole LIMP transaction at a time, from valid through the ready pulse, with round-robin fairness.
- Sits between both letc_core_cache instances and the AXI FSM.

Parameters:
- TIMEOUT_CYCLES, 256: grant-hold watchdog limit. Used only with the optional feature.

Ports:
- i_clk  in  1  core clock
- i_rst_n  in  1  asynchronous active-low reset
- i_req0_valid  in  1  requester 0 LIMP valid
- o_req0_ready  out  1  requester 0 LIMP ready (completion pulse)
- i_req0_wen_nren  in  1  requester 0 write enable / not read enable
- i_req0_size  in  size_e  requester 0 access size
- i_req0_addr  in  paddr_t  requester 0 physical address
- o_req0_rdata  out  word_t  requester 0 read data
- i_req0_wdata  in  word_t  requester 0 write data
- i_req1_* / o_req1_*  (same seven signals, same widths)  requester 1 LIMP
- o_mem_valid  out  1  downstream LIMP valid to AXI FSM
- i_mem_ready  in  1  downstream LIMP ready
- o_mem_wen_nren  out  1  downstream write enable / not read enable
- o_mem_size  out  size_e  downstream access size
- o_mem_addr  out  paddr_t  downstream address
- i_mem_rdata  in  word_t  downstream read data
- o_mem_wdata  out  word_t  downstream write data
- o_timeout  out  1  watchdog flag (optional feature only; tied 0 otherwise)

Behaviour:
- LIMP rules:
  - A requester holds valid high with stable wen_nren/size/addr/wdata until it sees ready high for one cycle.
  - Ready is a single-cycle completion pulse; rdata is valid in that cycle.
  - A requester may raise valid again in the cycle after ready.
- FSM states:
  - IDLE: no grant.
  - GRANT0: requester 0 owns the downstream port.
  - GRANT1: requester 1 owns the downstream port.
  - The state and a last_grant register are both flopped.
- IDLE:
  - Only one valid: go to that requester's GRANT state next cycle.
  - Both valid: grant the requester that is not last_grant.
  - Neither valid: stay in IDLE.
  - Arbitration adds exactly one cycle; o_mem_valid rises the cycle after the winning valid is sampled.
- GRANTn:
  - o_mem_valid = i_reqn_valid.
  - o_mem_wen_nren/size/addr/wdata = requester n's fields (combinational mux).
  - o_reqn_ready = i_mem_ready.
  - The other requester's ready = 0.
- Completion (GRANTn and i_mem_ready):
  - last_grant <= n.
  - If the other requester is valid in the same cycle, go directly to its GRANT state (back-to-back, no IDLE bubble).
  - Else if requester n is valid again, it is the next grant only if the other is idle; in this arbiter it goes to IDLE.
  - Else go to IDLE.
- Grants are never preempted before i_mem_ready.
- o_req0_rdata and o_req1_rdata are both driven from i_mem_rdata (fan-out); only ready qualifies the data.
- i_mem_ready while IDLE is ignored and produces no ready pulse to either requester.
- In IDLE: o_mem_valid = 0 and all o_mem_* fields = 0.
- Requester n dropping valid in GRANTn before ready is a protocol violation. Flag it with a simulation assertion; the RTL behaviour is to keep the grant.
- Reset values (asynchronous, effective immediately):
  - state = IDLE, last_grant = 1 (requester 0 wins the first tie).
  - o_mem_valid = 0, o_req0_ready = 0, o_req1_ready = 0, o_mem_* = 0, o_timeout = 0.
- Reset mid-transaction aborts the grant. Both caches and the AXI FSM are reset in the same domain, so no replay is needed.

Optional Feature:
- Macro: LETC_CORE_LIMP_ARB_WATCHDOG_EN.
- Enabled:
  - A counter of width $clog2(TIMEOUT_CYCLES+1) clears on every grant entry and increments each cycle while in GRANTn without i_mem_ready.
  - When it reaches TIMEOUT_CYCLES, o_timeout goes high and stays sticky until reset. The grant itself is unaffected.
- Disabled: no counter is built and o_timeout is tied to 0.

Test Plan:
- Reset, then req0 read at addr 0x0000_1000; memory returns ready 2 cycles after o_mem_valid with rdata 0xFFFF_EFFF.
  - Expect o_mem_valid one cycle after i_req0_valid, o_mem_addr 0x1000, o_req0_ready a single pulse with o_req0_rdata 0xFFFF_EFFF, and o_req1_ready never high.
- Both requesters raise valid in the same cycle right after reset.
  - Expect req0 granted first and req1 granted in the cycle after req0's ready with no IDLE cycle, giving 2 ready pulses in order 0 then 1.
- Both requesters hold valid continuously for 6 transactions on a zero-latency memory.
  - Expect grants alternating 0,1,0,1,0,1 and 3 completions each.
- req1 write of 0xDEAD_BEEF to 0x0000_2004, size SIZE_WORD, while req0 is idle.
  - Expect o_mem_wen_nren = 1, o_mem_wdata 0xDEAD_BEEF, o_mem_size SIZE_WORD; req0 unaffected.
- Assert i_rst_n low while in GRANT1 with memory not yet ready.
  - Expect o_mem_valid = 0 and both ready outputs = 0 within the same cycle.
  - After release, a new req1 request is granted normally.
- Watchdog enabled, TIMEOUT_CYCLES = 8, grant with memory ready held low.
  - Expect o_timeout rising after 8 stalled cycles and staying high after a later i_mem_ready.
  - Watchdog disabled: o_timeout stays 0.

Source files
------------

// File: rtl/letc_core_limp_arbiter.sv
// letc_core_limp_arbiter: round-robin arbiter of the icache/dcache LIMP ports onto the AXI FSM LIMP port.
// Optional grant-hold watchdog enabled by defining LETC_CORE_LIMP_ARB_WATCHDOG_EN.
module letc_core_limp_arbiter #(
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_req0_valid,
    output logic        o_req0_ready,
    input  logic        i_req0_wen_nren,
    input  logic [1:0]  i_req0_size,
    input  logic [31:0] i_req0_addr,
    output logic [31:0] o_req0_rdata,
    input  logic [31:0] i_req0_wdata,
    input  logic        i_req1_valid,
    output logic        o_req1_ready,
    input  logic        i_req1_wen_nren,
    input  logic [1:0]  i_req1_size,
    input  logic [31:0] i_req1_addr,
    output logic [31:0] o_req1_rdata,
    input  logic [31:0] i_req1_wdata,
    output logic        o_mem_valid,
    input  logic        i_mem_ready,
    output logic        o_mem_wen_nren,
    output logic [1:0]  o_mem_size,
    output logic [31:0] o_mem_addr,
    input  logic [31:0] i_mem_rdata,
    output logic [31:0] o_mem_wdata,
    output logic        o_timeout
);
    typedef enum logic [1:0] {IDLE, GRANT0, GRANT1} state_e;
    state_e state, state_next;
    logic last_grant, last_grant_next;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= IDLE;
            last_grant <= 1'b1;
        end else begin
            state      <= state_next;
            last_grant <= last_grant_next;
        end
    end
    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        o_mem_valid     = 1'b0;
        o_mem_wen_nren  = 1'b0;
        o_mem_size      = 2'd0;
        o_mem_addr      = 32'd0;
        o_mem_wdata     = 32'd0;
        o_req0_ready    = 1'b0;
        o_req1_ready    = 1'b0;
        case (state)
            IDLE: begin
                if (i_req0_valid && i_req1_valid)
                    state_next = last_grant ? GRANT0 : GRANT1;
                else if (i_req0_valid)
                    state_next = GRANT0;
                else if (i_req1_valid)
                    state_next = GRANT1;
            end
            GRANT0: begin
                o_mem_valid    = i_req0_valid;
                o_mem_wen_nren = i_req0_wen_nren;
                o_mem_size     = i_req0_size;
                o_mem_addr     = i_req0_addr;
                o_mem_wdata    = i_req0_wdata;
                o_req0_ready   = i_mem_ready;
                if (i_mem_ready) begin
                    last_grant_next = 1'b0;
                    state_next      = i_req1_valid ? GRANT1 : IDLE;
                end
            end
            GRANT1: begin
                o_mem_valid    = i_req1_valid;
                o_mem_wen_nren = i_req1_wen_nren;
                o_mem_size     = i_req1_size;
                o_mem_addr     = i_req1_addr;
                o_mem_wdata    = i_req1_wdata;
                o_req1_ready   = i_mem_ready;
                if (i_mem_ready) begin
                    last_grant_next = 1'b1;
                    state_next      = i_req0_valid ? GRANT0 : IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end
    assign o_req0_rdata = i_mem_rdata;
    assign o_req1_rdata = i_mem_rdata;
`ifdef LETC_CORE_LIMP_ARB_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_MAX = WD_W'(TIMEOUT_CYCLES);
    logic [WD_W-1:0] wd_cnt;
    logic wd_timeout, grant_entry, stalled;
    assign grant_entry = (state_next != IDLE) && (state_next != state);
    assign stalled     = (state != IDLE) && !i_mem_ready;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            wd_cnt     <= '0;
            wd_timeout <= 1'b0;
        end else begin
            if (grant_entry)
                wd_cnt <= '0;
            else if (stalled && wd_cnt != WD_MAX)
                wd_cnt <= wd_cnt + 1'b1;
            if (stalled && wd_cnt == WD_MAX - 1'b1)
                wd_timeout <= 1'b1;
        end
    end
    assign o_timeout = wd_timeout;
`else
    assign o_timeout = 1'b0;
`endif
    // An owner withdrawing valid mid-grant is a protocol bug; the grant is still held.
    a_req0_hold: assert property (@(posedge i_clk) disable iff (!i_rst_n) (state == GRANT0) |-> i_req0_valid);
    a_req1_hold: assert property (@(posedge i_clk) disable iff (!i_rst_n) (state == GRANT1) |-> i_req1_valid);
    a_timeout_cfg: assert property (@(posedge i_clk) TIMEOUT_CYCLES > 0);
endmodule

// File: tb/tb_letc_core_limp_arbiter.sv
// tb_letc_core_limp_arbiter: scoreboard bench for the LIMP round-robin arbiter.
module tb_letc_core_limp_arbiter;
    localparam logic [1:0] SIZE_BYTE = 2'b00;
    localparam logic [1:0] SIZE_HALF = 2'b01;
    localparam logic [1:0] SIZE_WORD = 2'b10;
`ifdef LETC_CORE_LIMP_ARB_WATCHDOG_EN
    localparam logic WD_EXP = 1'b1;
`else
    localparam logic WD_EXP = 1'b0;
`endif
    typedef struct {
        int          id;
        logic        wen;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;
    logic clk = 1'b0, rst_n = 1'b0;
    logic r0_valid = 1'b0, r0_wen = 1'b0, r1_valid = 1'b0, r1_wen = 1'b0;
    logic [1:0] r0_size = 2'd0, r1_size = 2'd0;
    logic [31:0] r0_addr = 32'd0, r0_wdata = 32'd0, r1_addr = 32'd0, r1_wdata = 32'd0;
    logic o_req0_ready, o_req1_ready, o_mem_valid, o_mem_wen_nren, o_timeout;
    logic [31:0] o_req0_rdata, o_req1_rdata, o_mem_addr, o_mem_wdata, mem_rdata;
    logic [1:0] o_mem_size;
    logic mem_ready, mem_en = 1'b1, mem_force = 1'b0;
    logic [7:0] mem_cnt = 8'd0, mem_lat = 8'd0;
    exp_t sb[$];
    exp_t e;
    int n_cmp = 0, n_err = 0, rdy0_cnt = 0, rdy1_cnt = 0, base0, base1;
    always #5 clk = ~clk;
    letc_core_limp_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_req0_valid(r0_valid), .o_req0_ready(o_req0_ready), .i_req0_wen_nren(r0_wen),
        .i_req0_size(r0_size), .i_req0_addr(r0_addr), .o_req0_rdata(o_req0_rdata), .i_req0_wdata(r0_wdata),
        .i_req1_valid(r1_valid), .o_req1_ready(o_req1_ready), .i_req1_wen_nren(r1_wen),
        .i_req1_size(r1_size), .i_req1_addr(r1_addr), .o_req1_rdata(o_req1_rdata), .i_req1_wdata(r1_wdata),
        .o_mem_valid(o_mem_valid), .i_mem_ready(mem_ready), .o_mem_wen_nren(o_mem_wen_nren),
        .o_mem_size(o_mem_size), .o_mem_addr(o_mem_addr), .i_mem_rdata(mem_rdata),
        .o_mem_wdata(o_mem_wdata), .o_timeout(o_timeout)
    );
    // Memory model: ready mem_lat cycles after valid, read data is the inverted address.
    assign mem_ready = mem_force || (o_mem_valid && mem_en && mem_cnt >= mem_lat);
    assign mem_rdata = ~o_mem_addr;
    always @(posedge clk) mem_cnt <= (!o_mem_valid || mem_ready) ? 8'd0 : mem_cnt + 8'd1;
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    task automatic tick();
        @(posedge clk);
        #1;
    endtask
    task automatic push(input int id, input logic wen, input logic [1:0] size, input logic [31:0] addr,
                        input logic [31:0] wdata);
        exp_t x;
        x.id = id; x.wen = wen; x.size = size; x.addr = addr; x.wdata = wdata;
        sb.push_back(x);
    endtask
    task automatic do_req(input int id, input logic wen, input logic [1:0] size, input logic [31:0] addr,
                          input logic [31:0] wdata);
        int n = 0;
        if (id == 0) begin
            r0_wen = wen; r0_size = size; r0_addr = addr; r0_wdata = wdata; r0_valid = 1'b1;
        end else begin
            r1_wen = wen; r1_size = size; r1_addr = addr; r1_wdata = wdata; r1_valid = 1'b1;
        end
        do begin
            @(negedge clk);
            n++;
        end while (!(id == 0 ? o_req0_ready : o_req1_ready) && n < 200);
        if (n >= 200) check("req_wait", 32'(id), 32'hFFFF_FFFF);
        tick();
        if (id == 0) r0_valid = 1'b0;
        else r1_valid = 1'b0;
    endtask
    task automatic wait_ready0();
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!o_req0_ready && n < 200);
        if (n >= 200) check("wait_ready0", 0, 1);
    endtask
    always @(negedge clk) begin
        if (o_req0_ready || o_req1_ready) begin
            check("rdy_exclusive", {o_req0_ready, o_req1_ready}, o_req0_ready ? 2'b10 : 2'b01);
            if (sb.size() == 0) check("sb_unexpected", {o_req0_ready, o_req1_ready}, 0);
            else begin
                e = sb.pop_front();
                check("sb_id", 32'(o_req1_ready), e.id);
                check("sb_addr", o_mem_addr, e.addr);
                check("sb_wen", o_mem_wen_nren, e.wen);
                check("sb_size", o_mem_size, e.size);
                check("sb_wdata", o_mem_wdata, e.wdata);
                check("sb_rdata", o_req1_ready ? o_req1_rdata : o_req0_rdata, ~e.addr);
            end
            rdy0_cnt += int'(o_req0_ready);
            rdy1_cnt += int'(o_req1_ready);
        end
    end
    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end
    initial begin
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_mem_valid", o_mem_valid, 0);
        check("rst_ready", {o_req0_ready, o_req1_ready}, 0);
        check("rst_mem_addr", o_mem_addr, 0);
        check("rst_timeout", o_timeout, 0);
        tick();
        rst_n = 1'b1;
        tick();
        mem_lat = 8'd2;
        push(0, 1'b0, SIZE_WORD, 32'h0000_1000, 32'd0);
        fork
            do_req(0, 1'b0, SIZE_WORD, 32'h0000_1000, 32'd0);
            begin
                @(negedge clk);
                check("p1_valid_early", o_mem_valid, 0);
                @(negedge clk);
                check("p1_valid", o_mem_valid, 1);
                check("p1_addr", o_mem_addr, 32'h0000_1000);
                check("p1_rdy_lat0", o_req0_ready, 0);
                @(negedge clk);
                check("p1_rdy_lat1", o_req0_ready, 0);
                @(negedge clk);
                check("p1_rdy", o_req0_ready, 1);
                check("p1_rdata", o_req0_rdata, 32'hFFFF_EFFF);
                @(negedge clk);
                check("p1_single_pulse", o_req0_ready, 0);
            end
        join
        check("p1_cnt0", rdy0_cnt, 1);
        check("p1_cnt1", rdy1_cnt, 0);
        tick();
        mem_force = 1'b1;
        @(negedge clk);
        check("idle_ready_ignored", {o_req0_ready, o_req1_ready}, 0);
        tick();
        mem_force = 1'b0;
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        mem_lat = 8'd1;
        base0 = rdy0_cnt;
        base1 = rdy1_cnt;
        push(0, 1'b0, SIZE_WORD, 32'h0000_0100, 32'd0);
        push(1, 1'b0, SIZE_WORD, 32'h0000_0200, 32'd0);
        fork
            do_req(0, 1'b0, SIZE_WORD, 32'h0000_0100, 32'd0);
            do_req(1, 1'b0, SIZE_WORD, 32'h0000_0200, 32'd0);
            begin
                wait_ready0();
                @(negedge clk);
                check("p2_no_bubble", o_mem_valid, 1);
                check("p2_b2b_addr", o_mem_addr, 32'h0000_0200);
            end
        join
        check("p2_cnt0", rdy0_cnt - base0, 1);
        check("p2_cnt1", rdy1_cnt - base1, 1);
        mem_lat = 8'd0;
        base0 = rdy0_cnt;
        base1 = rdy1_cnt;
        for (int i = 0; i < 3; i++) begin
            push(0, 1'b0, SIZE_HALF, 32'h3000 + 4 * i, 32'd0);
            push(1, 1'(i), SIZE_BYTE, 32'h4000 + 4 * i, 32'h55 + i);
        end
        fork
            for (int i = 0; i < 3; i++) do_req(0, 1'b0, SIZE_HALF, 32'h3000 + 4 * i, 32'd0);
            for (int j = 0; j < 3; j++) do_req(1, 1'(j), SIZE_BYTE, 32'h4000 + 4 * j, 32'h55 + j);
        join
        check("p3_cnt0", rdy0_cnt - base0, 3);
        check("p3_cnt1", rdy1_cnt - base1, 3);
        tick();
        mem_lat = 8'd1;
        base0 = rdy0_cnt;
        push(1, 1'b1, SIZE_WORD, 32'h0000_2004, 32'hDEAD_BEEF);
        fork
            do_req(1, 1'b1, SIZE_WORD, 32'h0000_2004, 32'hDEAD_BEEF);
            begin
                repeat (2) @(negedge clk);
                check("p4_valid", o_mem_valid, 1);
                check("p4_wen", o_mem_wen_nren, 1);
                check("p4_wdata", o_mem_wdata, 32'hDEAD_BEEF);
                check("p4_size", o_mem_size, SIZE_WORD);
            end
        join
        check("p4_req0_quiet", rdy0_cnt - base0, 0);
        tick();
        mem_en = 1'b0;
        r1_wen = 1'b0; r1_size = SIZE_WORD; r1_addr = 32'h0000_6000; r1_wdata = 32'd0; r1_valid = 1'b1;
        repeat (2) @(negedge clk);
        check("p5_granted", o_mem_valid, 1);
        #1;
        rst_n = 1'b0;
        r1_valid = 1'b0;
        mem_force = 1'b1;
        #1;
        check("p5_rst_valid", o_mem_valid, 0);
        check("p5_rst_ready", {o_req0_ready, o_req1_ready}, 0);
        check("p5_rst_addr", o_mem_addr, 0);
        mem_force = 1'b0;
        mem_en = 1'b1;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        push(1, 1'b0, SIZE_HALF, 32'h0000_6008, 32'd0);
        do_req(1, 1'b0, SIZE_HALF, 32'h0000_6008, 32'd0);
        tick();
        mem_en = 1'b0;
        push(0, 1'b0, SIZE_WORD, 32'h0000_5000, 32'd0);
        fork
            do_req(0, 1'b0, SIZE_WORD, 32'h0000_5000, 32'd0);
            begin
                repeat (5) @(negedge clk);
                check("wd_early", o_timeout, 0);
                repeat (7) @(negedge clk);
                check("wd_fire", o_timeout, WD_EXP);
                #1;
                mem_en = 1'b1;
            end
        join
        tick();
        @(negedge clk);
        check("wd_sticky", o_timeout, WD_EXP);
        check("sb_drain", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
